pito_dmem_arbiter: RTL and testbench

- Shares the single-port data memory of the rv32 core subsystem between NUM_REQ requesters:
  - core LSU
  - CSR/debug unit
  - testbench program/data loader over the tb interface
  - one spare port
- Round-robin arbitration, one memory transaction per cycle, fixed 1-cycle memory read latency, per-requester response routing.
- Optional bus lock gives one requester exclusive access for read-modify-write sequences, with a watchdog.

---
 rtl/pito_pkg.sv | 33 +++
 rtl/pito_rr_arbiter.sv | 47 ++++
 rtl/pito_dmem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pito_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pito_pkg.sv
// pito_pkg: shared types for the rv32 data-memory arbiter.
//   DMEM_BE_W     byte-enable width for the default 32-bit data path
//   arb_state_t   arbiter FSM state (ARB / LOCKED)
//   dmem_req_t    one requester's transaction payload
//   dmem_rsp_t    registered response-pipeline entry {valid, owner, we}
package pito_pkg;

  localparam int PITO_ADDR_W  = 32;
  localparam int PITO_DATA_W  = 32;
  localparam int DMEM_BE_W    = PITO_DATA_W / 8;
  // Owner field sized for the largest supported requester count (8).
  localparam int PITO_OWNER_W = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [PITO_ADDR_W-1:0] addr;
    logic                   we;
    logic [PITO_DATA_W-1:0] wdata;
    logic [DMEM_BE_W-1:0]   be;
    logic                   lock;
  } dmem_req_t;

  typedef struct packed {
    logic                    valid;
    logic [PITO_OWNER_W-1:0] owner;
    logic                    we;
  } dmem_rsp_t;

endpackage

// File: rtl/pito_rr_arbiter.sv
// pito_rr_arbiter: combinational rotating-priority arbiter.
//   i_req      request vector
//   i_mask     requesters eligible this cycle
//   i_ptr      highest-priority index; priority falls off i_ptr, i_ptr+1, ...
//   o_gnt      one-hot grant (all zero when nothing eligible)
//   o_gnt_idx  encoded grant index (0 when no grant)
module pito_rr_arbiter
  import pito_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic [NUM_REQ-1:0] w_req;
  logic               w_found;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_j;

  assign w_req = i_req & i_mask;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // (ptr + k) mod NUM_REQ; one extra bit covers the 2*NUM_REQ-2 maximum.
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ))
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      w_j = w_sum[IDX_W-1:0];
      if (!w_found && w_req[w_j]) begin
        w_found       = 1'b1;
        o_gnt[w_j]    = 1'b1;
        o_gnt_idx     = w_j;
      end
    end
  end

endmodule

// File: rtl/pito_dmem_arbiter.sv
// pito_dmem_arbiter: shares the single-port data memory among NUM_REQ
// requesters with round-robin arbitration, optional exclusive bus lock
// guarded by an idle watchdog, and a 1-cycle response pipeline.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_* / o_req_ready   per-requester flattened request channel
//   o_rsp_valid/o_rsp_rdata one-cycle response pulse + shared read data
//   o_mem_* / i_mem_rdata   memory port (word address, 1-cycle read latency)
//   o_lock_owner, o_locked  lock status; o_lock_timeout pulses on watchdog release
module pito_dmem_arbiter
  import pito_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] i_req_be,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_W-3:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  output logic [DATA_W/8-1:0]           o_mem_be,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    o_lock_owner,
  output logic                          o_locked,
  output logic                          o_lock_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Per-requester views of the flattened buses.
  logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_wdata;
  logic [NUM_REQ-1:0][BE_W-1:0]   w_be;
  logic [NUM_REQ-1:0]             w_unused_addr_lsb;

  assign w_addr  = i_req_addr;
  assign w_wdata = i_req_wdata;
  assign w_be    = i_req_be;

  arb_state_t         r_state, w_state_n;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_n;
  logic [IDX_W-1:0]   r_owner, w_owner_n;
  logic [CNT_W-1:0]   r_idle_cnt, w_idle_cnt_n;
  logic               r_timeout, w_timeout_n;
  dmem_rsp_t          r_rsp, w_rsp_n;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + 1'b1;
  endfunction

  // While locked only the owner is eligible.
  always_comb begin
    w_mask = '1;
    if (r_state == LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  pito_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req     (i_req_valid),
    .i_mask    (w_mask),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_gnt_vld   = |w_gnt;
  assign o_req_ready = w_gnt;
  assign o_mem_en    = w_gnt_vld;
  assign o_mem_we    = w_gnt_vld & i_req_we[w_gnt_idx];
  assign o_mem_addr  = w_addr[w_gnt_idx][ADDR_W-1:2];
  assign o_mem_wdata = w_wdata[w_gnt_idx];
  assign o_mem_be    = w_be[w_gnt_idx];

  // Next-state: rr pointer, lock ownership and watchdog.
  always_comb begin
    w_state_n    = r_state;
    w_rr_ptr_n   = r_rr_ptr;
    w_owner_n    = r_owner;
    w_idle_cnt_n = r_idle_cnt;
    w_timeout_n  = 1'b0;
    unique case (r_state)
      ARB: begin
        if (w_gnt_vld) begin
          w_rr_ptr_n = inc_idx(w_gnt_idx);
          if (i_req_lock[w_gnt_idx]) begin
            w_state_n    = LOCKED;
            w_owner_n    = w_gnt_idx;
            w_idle_cnt_n = '0;
          end
        end
      end
      LOCKED: begin
        // An owner grant beats watchdog expiry in the same cycle.
        if (w_gnt_vld) begin
          w_idle_cnt_n = '0;
          if (!i_req_lock[r_owner]) begin
            w_state_n  = ARB;
            w_rr_ptr_n = inc_idx(r_owner);
            w_owner_n  = '0;
          end
        end else if (r_idle_cnt == CNT_W'(LOCK_MAX-1)) begin
          w_state_n    = ARB;
          w_owner_n    = '0;
          w_idle_cnt_n = '0;
          w_timeout_n  = 1'b1;
        end else begin
          w_idle_cnt_n = r_idle_cnt + 1'b1;
        end
      end
      default: w_state_n = ARB;
    endcase
  end

  always_comb begin
    w_rsp_n       = '0;
    w_rsp_n.valid = w_gnt_vld;
    w_rsp_n.owner = PITO_OWNER_W'(w_gnt_idx);
    w_rsp_n.we    = o_mem_we;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
      r_rsp      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_owner    <= w_owner_n;
      r_idle_cnt <= w_idle_cnt_n;
      r_timeout  <= w_timeout_n;
      r_rsp      <= w_rsp_n;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign o_rsp_valid[gi]       = r_rsp.valid && (r_rsp.owner == PITO_OWNER_W'(gi));
    // Byte offset is the requester's business; the memory is word addressed.
    assign w_unused_addr_lsb[gi] = ^w_addr[gi][1:0];
  end

  // Write acks and idle cycles return zero data.
  assign o_rsp_rdata    = (r_rsp.valid && !r_rsp.we) ? i_mem_rdata : '0;
  assign o_lock_owner   = r_owner;
  assign o_locked       = (r_state == LOCKED);
  assign o_lock_timeout = r_timeout;

endmodule

// File: tb/tb_pito_dmem_arbiter.sv
module tb_pito_dmem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        valid, ready, we, lock, rsp_valid;
  logic [3:0][31:0]  addr, wdata;
  logic [3:0][3:0]   be;
  logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we, locked, lock_timeout;
  logic [29:0]       mem_addr;
  logic [3:0]        mem_be;
  logic [1:0]        lock_owner;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  pito_dmem_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .LOCK_MAX(16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (valid),
    .o_req_ready    (ready),
    .i_req_addr     (addr),
    .i_req_we       (we),
    .i_req_wdata    (wdata),
    .i_req_be       (be),
    .i_req_lock     (lock),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_mem_en       (mem_en),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_be       (mem_be),
    .i_mem_rdata    (mem_rdata),
    .o_lock_owner   (lock_owner),
    .o_locked       (locked),
    .o_lock_timeout (lock_timeout)
  );

  // Memory with 1-cycle read latency and byte-enabled writes.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_reqs();
    valid = '0; we = '0; lock = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_reqs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_owner", lock_owner, 0);
    chk("rst_timeout", lock_timeout, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    rst = 1'b0;

    // Round robin: all four reading, grants 0,1,2,3,0,1.
    for (int i = 0; i < 4; i++) addr[i] = (i + 1) * 16;
    valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", ready, 4'b1 << (c % 4));
      chk("rr_maddr", mem_addr, (c % 4 + 1) * 4);
      if (c > 0) begin
        chk("rr_rsp_valid", rsp_valid, 4'b1 << ((c - 1) % 4));
        chk("rr_rsp_rdata", rsp_rdata, 32'hA000_0000 + ((c - 1) % 4 + 1) * 4);
      end
      @(negedge clk);
    end
    valid = '0;
    #1;
    chk("rr_last_rsp", rsp_valid, 4'b0010);
    chk("rr_last_rdata", rsp_rdata, 32'hA000_0008);
    chk("rr_idle_en", mem_en, 0);
    @(negedge clk);
    #1;
    chk("rr_idle_rsp", rsp_valid, 0);
    chk("rr_idle_rdata", rsp_rdata, 0);

    // Write by requester 2, read back by requester 0.
    do_reset();
    valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h100; wdata[2] = 32'hDEAD_BEEF; be[2] = 4'hF;
    #1;
    chk("wr_ready", ready, 4'b0100);
    chk("wr_maddr", mem_addr, 30'h40);
    chk("wr_mwe", mem_we, 1);
    chk("wr_mwdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_mbe", mem_be, 4'hF);
    @(negedge clk);
    valid[2] = 1'b0; we[2] = 1'b0;
    valid[0] = 1'b1; addr[0] = 32'h100;
    #1;
    chk("rd_ready", ready, 4'b0001);
    chk("rd_maddr", mem_addr, 30'h40);
    chk("rd_mwe", mem_we, 0);
    chk("wack_valid", rsp_valid, 4'b0100);
    chk("wack_rdata", rsp_rdata, 0);
    @(negedge clk);
    valid = '0;
    #1;
    chk("rd_rsp_valid", rsp_valid, 4'b0001);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Lock by requester 1 while 0 and 3 wait.
    do_reset();
    valid[0] = 1'b1;
    #1;
    chk("lk_pre_ready", ready, 4'b0001);
    @(negedge clk);
    valid = 4'b1011; lock[1] = 1'b1; addr[1] = 32'h20; addr[3] = 32'h30;
    #1;
    chk("lk_grant", ready, 4'b0010);
    chk("lk_not_yet", locked, 0);
    @(negedge clk);
    #1;
    chk("lk_locked", locked, 1);
    chk("lk_owner", lock_owner, 1);
    chk("lk_hold_ready", ready, 4'b0010);
    chk("lk_rsp", rsp_valid, 4'b0010);
    @(negedge clk);
    valid[1] = 1'b0;
    #1;
    chk("lk_idle_ready", ready, 0);
    chk("lk_idle_en", mem_en, 0);
    chk("lk_idle_locked", locked, 1);
    @(negedge clk);
    valid[1] = 1'b1; lock[1] = 1'b0;
    #1;
    chk("ulk_ready", ready, 4'b0010);
    chk("ulk_still", locked, 1);
    @(negedge clk);
    valid[1] = 1'b0;
    #1;
    chk("ulk_locked", locked, 0);
    chk("ulk_owner", lock_owner, 0);
    chk("ulk_next3", ready, 4'b1000);
    @(negedge clk);
    valid[3] = 1'b0;
    #1;
    chk("ulk_next0", ready, 4'b0001);
    @(negedge clk);

    // Watchdog: requester 3 locks then goes idle for LOCK_MAX cycles.
    do_reset();
    valid[3] = 1'b1; lock[3] = 1'b1;
    #1;
    chk("wd_grant", ready, 4'b1000);
    @(negedge clk);
    valid[3] = 1'b0; lock[3] = 1'b0; valid[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("wd_hold_ready", ready, 0);
      chk("wd_hold_to", lock_timeout, 0);
      chk("wd_hold_locked", locked, 1);
      @(negedge clk);
    end
    #1;
    chk("wd_timeout", lock_timeout, 1);
    chk("wd_released", locked, 0);
    chk("wd_next0", ready, 4'b0001);
    @(negedge clk);
    #1;
    chk("wd_pulse_end", lock_timeout, 0);
    @(negedge clk);

    // Reset on the edge that accepts a read: response dropped, lock not taken.
    do_reset();
    valid[1] = 1'b1; addr[1] = 32'h40;
    #1;
    chk("rs_ready", ready, 4'b0010);
    @(negedge clk);
    lock[1] = 1'b1;
    rst = 1'b1;
    #1;
    chk("rs_rsp_before", rsp_valid, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    clr_reqs();
    #1;
    chk("rs_rsp_dropped", rsp_valid, 0);
    chk("rs_rdata", rsp_rdata, 0);
    chk("rs_locked", locked, 0);
    chk("rs_owner", lock_owner, 0);
    chk("rs_timeout", lock_timeout, 0);
    valid = 4'hF;
    #1;
    chk("rs_first_grant", ready, 4'b0001);
    @(negedge clk);

    // Unlock lands in the same cycle the watchdog would expire.
    do_reset();
    valid[2] = 1'b1; lock[2] = 1'b1;
    #1;
    chk("ue_grant", ready, 4'b0100);
    @(negedge clk);
    valid[2] = 1'b0; lock[2] = 1'b0; valid[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("ue_hold_ready", ready, 0);
      @(negedge clk);
    end
    valid[2] = 1'b1; addr[2] = 32'h8;
    #1;
    chk("ue_unlock_ready", ready, 4'b0100);
    chk("ue_unlock_to", lock_timeout, 0);
    @(negedge clk);
    valid[2] = 1'b0;
    #1;
    chk("ue_no_timeout", lock_timeout, 0);
    chk("ue_arb", locked, 0);
    chk("ue_rsp", rsp_valid, 4'b0100);
    chk("ue_rdata", rsp_rdata, 32'hA000_0002);
    chk("ue_next0", ready, 4'b0001);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
